// File: rtl/flight_mode_ctrl.sv
// Flight mode sequencer: hold/cruise velocity modes plus a charge/warp/cooldown jump sequence.
// All outputs are registered from the next-state decode, so they change only on a clock edge.
module flight_mode_ctrl #(
  parameter int unsigned WARP_CHARGE  = 4,
  parameter int unsigned COOLDOWN_CYC = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  input  logic [2:0] cmd,
  input  logic       abort,
  output logic       cmd_ready,
  output logic [3:0] mode_sel,
  output logic [3:0] pos_sel,
  output logic       cmd_err,
  output logic       warp_busy,
  output logic [7:0] warp_count
);

  typedef enum logic [2:0] {ZEROPOS, HOLD, CRUISE, CHARGE, WARP, COOLDOWN} state_t;

  localparam logic [3:0] M_ZERO    = 4'b0001;
  localparam logic [3:0] M_ATTACK  = 4'b0010;
  localparam logic [3:0] M_DEFENSE = 4'b0100;
  localparam logic [3:0] M_STEALTH = 4'b1000;

  localparam logic [3:0] P_CLEAR = 4'b0001;
  localparam logic [3:0] P_INTEG = 4'b0010;
  localparam logic [3:0] P_JUMP  = 4'b0100;

  state_t     state, state_nxt;
  logic [3:0] mode_lat, mode_nxt;
  logic [7:0] cnt, cnt_nxt;
  logic       accept, illegal, warp_entry;

  assign accept = cmd_valid && cmd_ready;

  function automatic logic [3:0] pos_decode(input state_t s);
    case (s)
      ZEROPOS: pos_decode = P_CLEAR;
      WARP:    pos_decode = P_JUMP;
      default: pos_decode = P_INTEG;
    endcase
  endfunction

  always_comb begin
    state_nxt  = state;
    mode_nxt   = mode_lat;
    cnt_nxt    = cnt;
    illegal    = 1'b0;
    warp_entry = 1'b0;
    case (state)
      ZEROPOS: state_nxt = HOLD;
      HOLD, CRUISE: begin
        if (accept) begin
          case (cmd)
            3'd0: begin state_nxt = ZEROPOS; mode_nxt = M_ZERO;    end
            3'd1: begin state_nxt = CRUISE;  mode_nxt = M_ATTACK;  end
            3'd2: begin state_nxt = CRUISE;  mode_nxt = M_DEFENSE; end
            3'd3: begin state_nxt = CRUISE;  mode_nxt = M_STEALTH; end
            3'd4: begin state_nxt = CHARGE;  cnt_nxt  = 8'(WARP_CHARGE); end
            default: illegal = 1'b1;
          endcase
        end
      end
      CHARGE: begin
        // abort wins over the counter reaching its last cycle
        if (abort) begin
          state_nxt = HOLD;
          cnt_nxt   = 8'd0;
        end else if (cnt == 8'd1) begin
          state_nxt  = WARP;
          mode_nxt   = M_ZERO;
          warp_entry = 1'b1;
        end else begin
          cnt_nxt = cnt - 8'd1;
        end
      end
      WARP: begin
        state_nxt = COOLDOWN;
        cnt_nxt   = 8'(COOLDOWN_CYC);
      end
      COOLDOWN: begin
        if (cnt == 8'd1) begin
          state_nxt = HOLD;
          cnt_nxt   = 8'd0;
        end else begin
          cnt_nxt = cnt - 8'd1;
        end
      end
      default: state_nxt = ZEROPOS;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ZEROPOS;
      mode_lat   <= M_ZERO;
      cnt        <= 8'd0;
      mode_sel   <= M_ZERO;
      pos_sel    <= P_CLEAR;
      cmd_ready  <= 1'b0;
      cmd_err    <= 1'b0;
      warp_busy  <= 1'b0;
      warp_count <= 8'd0;
    end else begin
      state     <= state_nxt;
      mode_lat  <= mode_nxt;
      cnt       <= cnt_nxt;
      mode_sel  <= (state_nxt == CRUISE) ? mode_nxt : M_ZERO;
      pos_sel   <= pos_decode(state_nxt);
      cmd_ready <= (state_nxt == HOLD) || (state_nxt == CRUISE);
      cmd_err   <= accept && illegal;
      warp_busy <= (state_nxt == CHARGE) || (state_nxt == WARP) || (state_nxt == COOLDOWN);
      if (warp_entry && (warp_count != 8'hFF))
        warp_count <= warp_count + 8'd1;
    end
  end

endmodule

// File: doc/flight_mode_ctrl.md
FLIGHT_MODE_CTRL -- requirements
Module: flight_mode_ctrl

Interface
REQ-001 Parameter WARP_CHARGE, default 4: cycles spent in CHARGE before the warp jump (legal 1..15).
REQ-002 Parameter COOLDOWN_CYC, default 8: cycles spent in COOLDOWN after a warp (legal 1..255).
REQ-003 clk  input  1  single clock, all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 cmd_valid  input  1  command present.
REQ-006 cmd  input  3  0=ZERO, 1=ATTACK, 2=DEFENSE, 3=STEALTH, 4=WARP, 5..7 illegal.
REQ-007 abort  input  1  cancels a pending warp while in CHARGE.
REQ-008 cmd_ready  output  1  block can accept a command this cycle.
REQ-009 mode_sel  output  4  one-hot velocity select: 0001 zero, 0010 attack, 0100 defense, 1000 stealth.
REQ-010 pos_sel  output  4  one-hot position select: 0001 clear, 0010 integrate, 0100 warp jump; 1000 never driven.
REQ-011 cmd_err  output  1  one-cycle pulse on acceptance of an illegal code.
REQ-012 warp_busy  output  1  high in CHARGE, WARP, COOLDOWN.
REQ-013 warp_count  output  8  number of completed warp jumps, saturating.

Function
REQ-014 States: ZEROPOS, HOLD, CRUISE, CHARGE, WARP, COOLDOWN.
REQ-015 Every output is a registered signal; mode_sel, pos_sel, cmd_ready and warp_busy decode the state register, so they change only on a clock edge.
REQ-016 Handshake: a command is accepted on a rising edge where cmd_valid=1 and cmd_ready=1. A command with cmd_ready=0 is ignored, not queued.
REQ-017 cmd_ready is 1 in HOLD and CRUISE, and 0 in every other state.
REQ-018 State outputs:
- ZEROPOS: mode 0001, pos 0001.
- HOLD: mode 0001, pos 0010.
- CRUISE: mode equals the latched mode, pos 0010.
- CHARGE: mode 0001, pos 0010.
- WARP: mode 0001, pos 0100.
- COOLDOWN: mode 0001, pos 0010.
REQ-019 ZEROPOS lasts exactly 1 cycle, then goes to HOLD.
REQ-020 Accepted ZERO goes to ZEROPOS. Accepted ATTACK, DEFENSE or STEALTH latches the mode and goes to (or stays in) CRUISE. The new mode_sel is visible the cycle after acceptance.
REQ-021 Accepted WARP goes to CHARGE and loads a down-counter with WARP_CHARGE.
REQ-022 CHARGE decrements the counter each cycle. When the counter is 1 it goes to WARP, giving exactly WARP_CHARGE cycles in CHARGE.
REQ-023 abort=1 in CHARGE goes to HOLD on the next edge and takes priority over the counter expiring; no warp occurs and warp_count is unchanged. abort is ignored in all other states.
REQ-024 WARP lasts exactly 1 cycle (pos_sel=0100 for one cycle). On entry warp_count increments, saturating at 255.
REQ-025 COOLDOWN lasts exactly COOLDOWN_CYC cycles, then goes to HOLD. The latched cruise mode is cleared to zero on warp entry.
REQ-026 An accepted illegal code (5..7) leaves state and latched mode unchanged and pulses cmd_err high for the following cycle only.
REQ-027 mode_sel and pos_sel are exactly one-hot in every cycle, including the cycle following reset release; 0000 and multi-hot values are never driven.
REQ-028 Back-to-back commands are accepted every cycle while cmd_ready=1; the last accepted command wins.

Reset
REQ-029 rst_n=0 forces, immediately and asynchronously:
- state ZEROPOS, mode_sel 0001, pos_sel 0001;
- cmd_ready 0, cmd_err 0, warp_busy 0;
- warp_count 0, latched mode zero, counters 0.
REQ-030 Reset asserted mid-CHARGE or mid-COOLDOWN abandons the sequence. After release the block reaches HOLD one cycle after the first edge.

Verification
REQ-031 Reset then release, idle inputs -> ZEROPOS (0001/0001) for 1 cycle, then HOLD with mode 0001, pos 0010, cmd_ready 1.
REQ-032 From HOLD, cmd=2 accepted, then cmd=3 the next cycle -> mode_sel 0100 for one cycle, then 1000; pos_sel stays 0010 throughout.
REQ-033 From CRUISE ATTACK, cmd=4 accepted, defaults -> CHARGE 4 cycles (cmd_ready 0), WARP 1 cycle (pos 0100), COOLDOWN 8 cycles, then HOLD. warp_count reads 1; warp_busy is high for 13 cycles.
REQ-034 WARP accepted, abort=1 on the 2nd CHARGE cycle -> HOLD next cycle, pos_sel never 0100, warp_count unchanged. cmd=1 presented during CHARGE is not accepted.
REQ-035 cmd=6 accepted in CRUISE DEFENSE -> cmd_err high for exactly 1 cycle, mode_sel stays 0100.
REQ-036 256 warps completed -> warp_count holds 255. Reset asserted during the next COOLDOWN -> warp_count 0, outputs 0001/0001 with no clock edge.
